// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS slice: opcodes, functs, ALU controls,
// FSM states, trap causes and datapath select codes.
package mips_pkg;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] TC_NONE     = 2'b00;
  localparam logic [1:0] TC_ILLEGAL  = 2'b01;
  localparam logic [1:0] TC_TIMEOUT  = 2'b10;
  localparam logic [1:0] TC_MISALIGN = 2'b11;

  // PC next-value and ALUOut source selects
  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] AO_BTGT   = 2'd0;
  localparam logic [1:0] AO_ADDR   = 2'd1;
  localparam logic [1:0] AO_ALU    = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_TRAP
  } state_e;

  function automatic logic funct_ok(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) || (f == FN_OR) || (f == FN_SLT);
  endfunction

  function automatic logic [2:0] alu_ctl(input logic [5:0] f);
    case (f)
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SUB:  return ALU_SUB;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] ctl);
    case (ctl)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SUB: return a - b;
      ALU_SLT: return {31'd0, $signed(a) < $signed(b)};
      default: return a + b;
    endcase
  endfunction
endpackage

// File: rtl/mc_controller.sv
// Multicycle control FSM: sequences instructions over the shared memory port,
// tracks handshake wait cycles and latches the sticky trap state.
module mc_controller import mips_pkg::*; #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       eq_i,
  input  logic       misalign_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       retire_o,
  output logic       trap_o,
  output logic [1:0] trap_cause_o,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic [1:0] pcsrc_o,
  output logic       ab_we_o,
  output logic       ao_we_o,
  output logic [1:0] aosrc_o,
  output logic       mdr_we_o,
  output logic       iord_o,
  output logic       rf_we_o,
  output logic       rf_dst_rd_o,
  output logic       rf_mdr_o
);
  localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LIM_M1 = CW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

  state_e        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          trap_q;
  logic [1:0]    cause_q, cause_d;
  logic          mem_req, mem_we, hs, timeout, retire, rf_we;

  assign mem_req = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign mem_we  = (state_q == S_MEMWR);
  assign hs      = mem_req && mem_ready_i;
  // A ready arriving in the limit cycle completes the transfer instead of trapping
  assign timeout = (WAIT_LIMIT > 0) && mem_req && !mem_ready_i && (wcnt_q == LIM_M1);
  assign wcnt_d  = (mem_req && !mem_ready_i) ? wcnt_q + CW'(1) : '0;

  always_comb begin
    state_d = state_q;  cause_d = cause_q;
    ir_we_o = 1'b0;     pc_we_o = 1'b0;  pcsrc_o = PC_PLUS4;  ab_we_o = 1'b0;
    ao_we_o = 1'b0;     aosrc_o = AO_BTGT; mdr_we_o = 1'b0;   iord_o = 1'b0;
    rf_we = 1'b0;       rf_dst_rd_o = 1'b0; rf_mdr_o = 1'b0;  retire = 1'b0;
    case (state_q)
      S_FETCH: if (hs) begin
        ir_we_o = 1'b1; pc_we_o = 1'b1; state_d = S_DECODE;
      end
      S_DECODE: begin
        ab_we_o = 1'b1; ao_we_o = 1'b1;
        case (op_i)
          OP_R:         state_d = funct_ok(funct_i) ? S_EXEC : S_TRAP;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_TRAP;
        endcase
        if (state_d == S_TRAP) cause_d = TC_ILLEGAL;
      end
      S_MEMADR: begin
        ao_we_o = 1'b1; aosrc_o = AO_ADDR;
        if (misalign_i) begin
          state_d = S_TRAP; cause_d = TC_MISALIGN;
        end else begin
          state_d = (op_i == OP_LW) ? S_MEMRD : S_MEMWR;
        end
      end
      S_MEMRD: begin
        iord_o = 1'b1;
        if (hs) begin mdr_we_o = 1'b1; state_d = S_MEMWB; end
      end
      S_MEMWB: begin rf_we = 1'b1; rf_mdr_o = 1'b1; retire = 1'b1; state_d = S_FETCH; end
      S_MEMWR: begin
        iord_o = 1'b1;
        if (hs) begin retire = 1'b1; state_d = S_FETCH; end
      end
      S_EXEC:   begin ao_we_o = 1'b1; aosrc_o = AO_ALU; state_d = S_ALUWB; end
      S_ALUWB:  begin rf_we = 1'b1; rf_dst_rd_o = 1'b1; retire = 1'b1; state_d = S_FETCH; end
      S_ADDIEX: begin ao_we_o = 1'b1; aosrc_o = AO_ADDR; state_d = S_ADDIWB; end
      S_ADDIWB: begin rf_we = 1'b1; retire = 1'b1; state_d = S_FETCH; end
      S_BRANCH: begin
        pc_we_o = eq_i; pcsrc_o = PC_BRANCH; retire = 1'b1; state_d = S_FETCH;
      end
      S_JUMP:   begin pc_we_o = 1'b1; pcsrc_o = PC_JUMP; retire = 1'b1; state_d = S_FETCH; end
      default:  ;
    endcase
    if (timeout) begin
      state_d = S_TRAP; cause_d = TC_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      wcnt_q  <= '0;
      trap_q  <= 1'b0;
      cause_q <= TC_NONE;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      trap_q  <= (state_d == S_TRAP);
      cause_q <= cause_d;
    end
  end

  assign mem_req_o    = mem_req & reset;
  assign mem_we_o     = mem_we & reset;
  assign retire_o     = retire & reset;
  assign rf_we_o      = rf_we & reset;
  assign trap_o       = trap_q;
  assign trap_cause_o = cause_q;
endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath on a single valid/ready memory port; sequencing,
// wait-cycle timeout and trapping live in mc_controller.
module mc_datapath import mips_pkg::*; #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        instr_retired,
  output logic        trap,
  output logic [1:0]  trap_cause
);
  logic [31:0] pc_q, ir_q, a_q, b_q, ao_q, mdr_q;
  logic [31:0] pc_d, ao_d, imm_sx, addr_sum, rf_rs, rf_rt, rf_wd;
  logic [31:0] rf_q [32];
  logic [4:0]  rs, rt, rd, wa;
  logic        ir_we, pc_we, ab_we, ao_we, mdr_we, iord, rf_we, rf_dst_rd, rf_mdr;
  logic [1:0]  pcsrc, aosrc;

  mc_controller #(.WAIT_LIMIT(WAIT_LIMIT)) u_ctrl (
    .clk(clk), .reset(reset),
    .op_i(ir_q[31:26]), .funct_i(ir_q[5:0]), .eq_i(a_q == b_q),
    .misalign_i(|addr_sum[1:0]), .mem_ready_i(mem_ready),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .retire_o(instr_retired),
    .trap_o(trap), .trap_cause_o(trap_cause),
    .ir_we_o(ir_we), .pc_we_o(pc_we), .pcsrc_o(pcsrc), .ab_we_o(ab_we),
    .ao_we_o(ao_we), .aosrc_o(aosrc), .mdr_we_o(mdr_we), .iord_o(iord),
    .rf_we_o(rf_we), .rf_dst_rd_o(rf_dst_rd), .rf_mdr_o(rf_mdr)
  );

  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign imm_sx   = {{16{ir_q[15]}}, ir_q[15:0]};
  assign addr_sum = a_q + imm_sx;
  assign rf_rs    = (rs == 5'd0) ? '0 : rf_q[rs];
  assign rf_rt    = (rt == 5'd0) ? '0 : rf_q[rt];
  assign wa       = rf_dst_rd ? rd : rt;
  assign rf_wd    = rf_mdr ? mdr_q : ao_q;

  always_comb begin
    case (aosrc)
      AO_ADDR: ao_d = addr_sum;
      AO_ALU:  ao_d = alu(a_q, b_q, alu_ctl(ir_q[5:0]));
      default: ao_d = pc_q + {imm_sx[29:0], 2'b00};   // branch target, pc already +4
    endcase
    case (pcsrc)
      PC_BRANCH: pc_d = ao_q;
      PC_JUMP:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
      default:   pc_d = pc_q + 32'd4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      ao_q  <= '0;
      mdr_q <= '0;
    end else begin
      if (pc_we)  pc_q  <= pc_d;
      if (ir_we)  ir_q  <= mem_rdata;
      if (ab_we)  begin a_q <= rf_rs; b_q <= rf_rt; end
      if (ao_we)  ao_q  <= ao_d;
      if (mdr_we) mdr_q <= mem_rdata;
    end
  end

  // Register file holds no reset; r0 is never written
  always_ff @(posedge clk) begin
    if (rf_we && wa != 5'd0) rf_q[wa] <= rf_wd;
  end

  assign mem_addr  = iord ? ao_q : pc_q;
  assign mem_wdata = b_q;
  assign pc        = pc_q;
endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath with a wait-state-capable memory model.
module tb_mc_datapath;
  logic        clk = 1'b0, reset = 1'b0;
  logic        mem_req, mem_we, mem_ready = 1'b0, instr_retired, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0, pc;
  logic [1:0]  trap_cause;

  int n_chk = 0, n_fail = 0;
  logic [31:0] mem [256];
  int cyc, waited, stall_n, ret_cnt, last_ret, wr_cnt, req_cnt, rd40_cnt, r0;
  logic [31:0] stall_addr, last_waddr, last_wdata, s_addr, s_wdata;
  logic s_req, s_we, s_ret;
  bit hold_low;

  mc_datapath #(.RESET_PC(32'h0000_0000), .WAIT_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc(pc), .instr_retired(instr_retired),
    .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: memory responds at negedge, outputs sampled 1ns later, bookkeeping after posedge
  task automatic tick();
    int need;
    @(negedge clk);
    need = (mem_addr == stall_addr) ? stall_n : 0;
    if (mem_req && (hold_low || waited < need)) begin
      mem_ready = 1'b0; waited++;
    end else if (mem_req) begin
      mem_ready = 1'b1; mem_rdata = mem[mem_addr[9:2]]; waited = 0;
    end else begin
      mem_ready = 1'b0;
    end
    #1;
    s_req = mem_req; s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata; s_ret = instr_retired;
    if (s_req) req_cnt++;
    if (s_req && !s_we && s_addr == 32'h40) rd40_cnt++;
    @(posedge clk);
    if (reset) cyc++;
    if (s_req && s_we && mem_ready) begin
      mem[s_addr[9:2]] = s_wdata; wr_cnt++; last_waddr = s_addr; last_wdata = s_wdata;
    end
    if (s_ret) begin ret_cnt++; last_ret = cyc; end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; waited = 0;
    tick(); tick();
    reset = 1'b1; cyc = 0; ret_cnt = 0; wr_cnt = 0; req_cnt = 0; last_ret = 0;
  endtask

  initial begin
    stall_addr = 32'hFFFF_FFFF; stall_n = 0; hold_low = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0] = 32'h2001_0005;  // addi $1,$0,5
    mem[1] = 32'h2002_0007;  // addi $2,$0,7
    mem[2] = 32'h0022_1820;  // add  $3,$1,$2
    mem[3] = 32'hAC03_0040;  // sw   $3,0x40($0)
    mem[4] = 32'h8C04_0040;  // lw   $4,0x40($0)
    mem[5] = 32'hAC04_0044;  // sw   $4,0x44($0)
    mem[6] = 32'h0800_0040;  // j    0x100
    mem[8'h40] = 32'h1021_FFFF;  // beq $1,$1,-1 at 0x100

    reset = 1'b0; waited = 0;
    tick(); tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_trap", 32'(trap), 0);
    chk("rst_cause", 32'(trap_cause), 0);
    chk("rst_req", 32'(s_req), 0);
    chk("rst_ret", 32'(s_ret), 0);
    reset = 1'b1; cyc = 0; ret_cnt = 0; wr_cnt = 0; req_cnt = 0; last_ret = 0;

    repeat (16) tick();
    chk("prog_retires", ret_cnt, 4);
    chk("sw_retire_cyc", last_ret, 16);
    chk("sw_count", wr_cnt, 1);
    chk("sw_addr", last_waddr, 32'h40);
    chk("sw_data", last_wdata, 32'd12);
    chk("pc_after_prog", pc, 32'h10);

    stall_addr = 32'h40; stall_n = 3; rd40_cnt = 0;
    repeat (8) tick();
    chk("lw_addr_hold", rd40_cnt, 4);
    chk("lw_retire_cyc", last_ret, 24);
    repeat (4) tick();
    chk("lw_val_addr", last_waddr, 32'h44);
    chk("lw_val_data", last_wdata, 32'd12);
    chk("lw_val_cyc", last_ret, 28);
    repeat (3) tick();
    chk("j_target", pc, 32'h100);
    tick();
    chk("beq_fetch_pc", pc, 32'h104);
    repeat (2) tick();
    chk("beq_loop_pc", pc, 32'h100);
    chk("beq_retire_cyc", last_ret, 34);
    chk("retire_total", ret_cnt, 8);
    stall_addr = 32'hFFFF_FFFF;

    // Illegal opcode
    mem[0] = 32'hFC00_0000;
    do_reset();
    repeat (2) tick();
    chk("ill_trap", 32'(trap), 1);
    chk("ill_cause", 32'(trap_cause), 1);
    r0 = req_cnt;
    repeat (20) tick();
    chk("ill_no_req", req_cnt, r0);
    chk("ill_sticky", 32'(trap), 1);
    reset = 1'b0;
    mem[0] = 32'h0800_0041;      // j 0x104
    mem[8'h41] = 32'h0800_0040;  // j 0x100 at 0x104
    tick();
    chk("rst2_pc", pc, 32'h0);
    chk("rst2_trap", 32'(trap), 0);
    chk("rst2_cause", 32'(trap_cause), 0);
    reset = 1'b1;
    repeat (3) tick();
    chk("j_to_104", pc, 32'h104);
    repeat (3) tick();
    chk("j_at_104", pc, 32'h100);

    // Fetch timeout at WAIT_LIMIT=4
    do_reset();
    hold_low = 1'b1;
    repeat (3) tick();
    chk("to_before", 32'(trap), 0);
    tick();
    chk("to_trap", 32'(trap), 1);
    chk("to_cause", 32'(trap_cause), 2);
    hold_low = 1'b0; r0 = req_cnt;
    repeat (5) tick();
    chk("to_no_req", req_cnt, r0);

    // Ready exactly in the limit cycle wins
    do_reset();
    stall_addr = 32'h0; stall_n = 3;
    repeat (4) tick();
    chk("edge_no_trap", 32'(trap), 0);
    chk("edge_pc", pc, 32'h4);
    stall_addr = 32'hFFFF_FFFF;

    // Misaligned lw
    mem[0] = 32'h8C05_0002;
    do_reset();
    tick();
    r0 = req_cnt;
    repeat (2) tick();
    chk("mis_trap", 32'(trap), 1);
    chk("mis_cause", 32'(trap_cause), 3);
    repeat (5) tick();
    chk("mis_no_req", req_cnt, r0);

    // Reset during a stalled store
    mem[0] = 32'hAC00_0048;  // sw $0,0x48($0)
    do_reset();
    stall_addr = 32'h48; stall_n = 100;
    repeat (5) tick();
    chk("st_pend_req", 32'(s_req && s_we), 1);
    chk("st_pend_addr", s_addr, 32'h48);
    reset = 1'b0;
    tick();
    chk("st_rst_req", 32'(s_req), 0);
    reset = 1'b1; stall_addr = 32'hFFFF_FFFF;
    tick();
    chk("st_refetch", {s_addr[31:2], s_we, s_req}, 32'h1);
    chk("st_no_write", wr_cnt, 0);
    chk("st_no_retire", ret_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
